sram_audio_ctrl: RTL and testbench
==================================

SRAM_AUDIO_CTRL -- requirements
Module: sram_audio_ctrl

Interface
REQ-001 Parameter ADDR_W, default 18, meaning: SRAM word-address width.
REQ-002 Parameter ADDR_LAST, default 2^ADDR_W-1, meaning: highest usable SRAM word address.
REQ-003 The clock port SHALL be bclk, input, 1 bit, meaning: audio bit clock; all state updates occur on its rising edge.
REQ-004 The reset port SHALL be rst, input, 1 bit, meaning: reset, asynchronous and active-high.
REQ-005 key_play, key_rec, key_stop, key_pause SHALL be inputs, 1 bit each, meaning: single-cycle command pulses.
REQ-006 adc_req SHALL be an input, 1 bit, meaning: a recorded sample is valid on adc_data (one-cycle pulse).
REQ-007 adc_data SHALL be an input, 16 bits, meaning: sample to store.
REQ-008 dac_req SHALL be an input, 1 bit, meaning: the DAC requests the next sample (one-cycle pulse).
REQ-009 dac_data SHALL be an output, 16 bits, meaning: fetched sample.
REQ-010 dac_valid SHALL be an output, 1 bit, meaning: dac_data is valid (one-cycle pulse).
REQ-011 sram_addr SHALL be an output, ADDR_W bits, meaning: SRAM word address.
REQ-012 sram_wdata SHALL be an output, 16 bits, meaning: SRAM write data.
REQ-013 sram_rdata SHALL be an input, 16 bits, meaning: SRAM read data, valid in the cycle after sram_oe_n=0.
REQ-014 sram_we_n SHALL be an output, 1 bit, meaning: active-low SRAM write strobe.
REQ-015 sram_oe_n SHALL be an output, 1 bit, meaning: active-low SRAM output enable.
REQ-016 state SHALL be an output, 2 bits, meaning: IDLE=0, PLAY=1, REC=2, PAUSE=3.
REQ-017 end_addr SHALL be an output, ADDR_W bits, meaning: address after the last recorded sample.

Function
REQ-018 The FSM SHALL use states IDLE, PLAY, REC and PAUSE.
REQ-019 When key pulses coincide, priority SHALL be key_stop > key_pause > key_rec > key_play.
REQ-020 In IDLE: key_rec SHALL enter REC with addr=0; key_play SHALL enter PLAY with addr=0 only if end_addr!=0, otherwise stay in IDLE.
REQ-021 In PLAY or REC: key_pause SHALL enter PAUSE and remember the originating mode; key_stop SHALL enter IDLE.
REQ-022 In PAUSE: key_pause or key_play SHALL resume the remembered mode with addr unchanged; key_stop SHALL enter IDLE; key_rec SHALL be ignored.
REQ-023 In REC, adc_req SHALL produce in the same cycle sram_we_n=0 for exactly one cycle, sram_addr=addr and sram_wdata=adc_data; addr SHALL then increment and end_addr SHALL become addr+1.
REQ-024 In REC, a write at addr==ADDR_LAST SHALL complete, set end_addr=ADDR_LAST+1 (saturated to ADDR_LAST if it overflows ADDR_W), and enter IDLE.
REQ-025 In PLAY, dac_req SHALL assert sram_oe_n=0 for one cycle with sram_addr=addr; the next cycle SHALL latch sram_rdata into dac_data and pulse dac_valid (1-cycle latency); addr SHALL increment.
REQ-026 In PLAY, when the incremented addr equals end_addr, the FSM SHALL enter IDLE once the pending dac_valid has been issued.
REQ-027 adc_req outside REC and dac_req outside PLAY SHALL be ignored, with no SRAM strobe.
REQ-028 sram_we_n and sram_oe_n SHALL never both be 0 in the same cycle.
REQ-029 A stop or pause arriving with a read outstanding SHALL still deliver that dac_valid.
REQ-030 dac_data SHALL hold its last value between dac_valid pulses.
REQ-031 end_addr SHALL be unchanged by PLAY, PAUSE and IDLE, and SHALL be cleared to 0 on entry to REC.

Reset
REQ-032 While rst=1, regardless of bclk: state=IDLE, addr=0, end_addr=0, dac_data=0, dac_valid=0, sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_wdata=0.
REQ-033 A reset asserted mid-write or mid-read SHALL abort the operation with no further strobes and no dac_valid.

Configuration
REQ-034 With macro LOOP_PLAY_EN defined, reaching end_addr in PLAY SHALL wrap addr to 0 and remain in PLAY; without it, PLAY SHALL end in IDLE as in REQ-026.

Verification
REQ-035 Bench: key_rec, then 4 adc_req with data 0x1111..0x4444, then key_stop -> 4 we_n pulses at addresses 0..3; end_addr=4; state=IDLE.
REQ-036 Bench: after REQ-035, key_play, then 5 dac_req -> dac_valid with 0x1111..0x4444 one cycle after each of the first 4 requests; state=IDLE after the 4th; the 5th request is ignored (LOOP_PLAY_EN off).
REQ-037 Bench: key_pause mid-PLAY at addr=2, then 2 dac_req, then key_play -> no strobes while paused; playback resumes at address 2.
REQ-038 Bench: key_stop and key_play pulsed in the same cycle during PLAY -> state=IDLE.
REQ-039 Bench: rst asserted asynchronously during REC -> all outputs equal their reset values before the next bclk edge; end_addr=0.
REQ-040 Bench: with LOOP_PLAY_EN defined and end_addr=2, 5 dac_req -> samples read from addresses 0,1,0,1,0; state stays PLAY.

Source files
------------

// File: rtl/sram_audio_ctrl_if.sv
// SRAM bus between the audio record/playback controller (master) and the sample memory (slave).
interface sram_audio_ctrl_if #(
    parameter int ADDR_W = 18
);
    logic [ADDR_W-1:0] sram_addr;
    logic [15:0]       sram_wdata;
    logic [15:0]       sram_rdata;
    logic              sram_we_n;
    logic              sram_oe_n;

    modport master (
        output sram_addr,
        output sram_wdata,
        output sram_we_n,
        output sram_oe_n,
        input  sram_rdata
    );

    modport slave (
        input  sram_addr,
        input  sram_wdata,
        input  sram_we_n,
        input  sram_oe_n,
        output sram_rdata
    );
endinterface

// File: rtl/sram_audio_ctrl.sv
// Record/playback controller streaming 16-bit audio samples through a single-port SRAM.
// Optional feature macro LOOP_PLAY_EN: playback wraps to address 0 instead of stopping at end_addr.
module sram_audio_ctrl #(
    parameter int          ADDR_W    = 18,
    parameter int unsigned ADDR_LAST = (1 << ADDR_W) - 1
) (
    input  logic              bclk,
    input  logic              rst,
    input  logic              key_play,
    input  logic              key_rec,
    input  logic              key_stop,
    input  logic              key_pause,
    input  logic              adc_req,
    input  logic [15:0]       adc_data,
    input  logic              dac_req,
    output logic [15:0]       dac_data,
    output logic              dac_valid,
    output logic [1:0]        state,
    output logic [ADDR_W-1:0] end_addr,
    sram_audio_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_REC   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    typedef enum logic [2:0] {K_NONE, K_STOP, K_PAUSE, K_REC, K_PLAY} key_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(ADDR_LAST);

    state_t            cur, nxt;
    key_t              key;
    logic [ADDR_W-1:0] addr, addr_nxt, addr_inc, end_nxt;
    logic              resume_rec, resume_nxt;
    logic              rd_pend;
    logic [15:0]       dac_hold;
    logic              wr_en, rd_en;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge bclk or posedge rst) begin
        if (rst) begin
            cur        <= S_IDLE;
            addr       <= '0;
            end_addr   <= '0;
            resume_rec <= 1'b0;
            rd_pend    <= 1'b0;
            dac_hold   <= '0;
        end else begin
            cur        <= nxt;
            addr       <= addr_nxt;
            end_addr   <= end_nxt;
            resume_rec <= resume_nxt;
            rd_pend    <= rd_en;
            if (rd_pend) dac_hold <= bus.sram_rdata;
        end
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        nxt        = cur;
        addr_nxt   = addr;
        end_nxt    = end_addr;
        resume_nxt = resume_rec;
        addr_inc   = addr + 1'b1;
        wr_en      = (cur == S_REC)  && adc_req;
        rd_en      = (cur == S_PLAY) && dac_req;

        if (key_stop)       key = K_STOP;
        else if (key_pause) key = K_PAUSE;
        else if (key_rec)   key = K_REC;
        else if (key_play)  key = K_PLAY;
        else                key = K_NONE;

        case (cur)
            S_IDLE: begin
                if (key == K_REC) begin
                    nxt      = S_REC;
                    addr_nxt = '0;
                    end_nxt  = '0;
                end else if (key == K_PLAY && end_addr != '0) begin
                    nxt      = S_PLAY;
                    addr_nxt = '0;
                end
            end
            S_REC: begin
                if (key == K_STOP) nxt = S_IDLE;
                else if (key == K_PAUSE) begin
                    nxt        = S_PAUSE;
                    resume_nxt = 1'b1;
                end
                // A write in flight always lands; filling the last word overrides any key.
                if (wr_en) begin
                    addr_nxt = addr_inc;
                    end_nxt  = (addr == '1) ? addr : addr_inc;
                    if (addr == LAST) nxt = S_IDLE;
                end
            end
            S_PLAY: begin
                if (key == K_STOP) nxt = S_IDLE;
                else if (key == K_PAUSE) begin
                    nxt        = S_PAUSE;
                    resume_nxt = 1'b0;
                end
                if (rd_en) begin
                    addr_nxt = addr_inc;
                    if (addr_inc == end_addr) begin
`ifdef LOOP_PLAY_EN
                        addr_nxt = '0;
`else
                        nxt = S_IDLE;
`endif
                    end
                end
            end
            S_PAUSE: begin
                if (key == K_STOP) nxt = S_IDLE;
                else if (key == K_PAUSE || key == K_PLAY) nxt = resume_rec ? S_REC : S_PLAY;
            end
            default: nxt = S_IDLE;
        endcase
    end

    // Strobes follow the request in the same cycle; the read sample is shown while it is on the bus.
    assign bus.sram_we_n  = ~wr_en;
    assign bus.sram_oe_n  = ~rd_en;
    assign bus.sram_addr  = addr;
    assign bus.sram_wdata = wr_en ? adc_data : 16'h0000;
    assign dac_valid      = rd_pend;
    assign dac_data       = rd_pend ? bus.sram_rdata : dac_hold;
    assign state          = cur;
endmodule

// File: tb/tb_sram_audio_ctrl.sv
// Self-checking bench for sram_audio_ctrl: directed scenarios plus random traffic against a behavioural model.
// Builds with or without LOOP_PLAY_EN; the loop-only scenario is guarded by that macro.
module tb_sram_audio_ctrl;
    localparam int AW       = 4;
    localparam int AL       = (1 << AW) - 1;
    localparam int END_FULL = (AL + 1 > (1 << AW) - 1) ? AL : AL + 1;
    localparam int ST_IDLE = 0, ST_PLAY = 1, ST_REC = 2, ST_PAUSE = 3;
    localparam logic [3:0] K_NO = 4'b0000, K_PLAY = 4'b0001, K_REC = 4'b0010,
                           K_PAUSE = 4'b0100, K_STOP = 4'b1000;

    logic          bclk = 1'b0;
    logic          rst;
    logic          key_play, key_rec, key_stop, key_pause;
    logic          adc_req, dac_req;
    logic [15:0]   adc_data;
    logic [15:0]   dac_data;
    logic          dac_valid;
    logic [1:0]    state;
    logic [AW-1:0] end_addr;

    int errors = 0;
    int checks = 0;

    sram_audio_ctrl_if #(.ADDR_W(AW)) sif ();

    sram_audio_ctrl #(.ADDR_W(AW)) dut (
        .bclk      (bclk),
        .rst       (rst),
        .key_play  (key_play),
        .key_rec   (key_rec),
        .key_stop  (key_stop),
        .key_pause (key_pause),
        .adc_req   (adc_req),
        .adc_data  (adc_data),
        .dac_req   (dac_req),
        .dac_data  (dac_data),
        .dac_valid (dac_valid),
        .state     (state),
        .end_addr  (end_addr),
        .bus       (sif)
    );

    always #5 bclk = ~bclk;

    // Synchronous-read SRAM: data appears in the cycle after output enable.
    logic [15:0] sram_mem [1 << AW];
    always @(posedge bclk) begin
        if (!sif.sram_we_n) sram_mem[sif.sram_addr] <= sif.sram_wdata;
        if (!sif.sram_oe_n) sif.sram_rdata <= sram_mem[sif.sram_addr];
    end

    // Behavioural reference model.
    int            m_state;
    logic [AW-1:0] m_addr, m_end;
    bit            m_resume_rec, m_pend;
    logic [15:0]   m_pend_data, m_dac;
    logic [15:0]   ref_mem [1 << AW];

    logic          obs_we_n, obs_oe_n, obs_valid;
    logic [15:0]   obs_data;
    logic [AW-1:0] obs_addr, obs_end;
    logic [1:0]    obs_state;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = ST_IDLE; m_addr = '0; m_end = '0;
        m_resume_rec = 0; m_pend = 0; m_pend_data = '0; m_dac = '0;
    endtask

    task automatic model_step(input logic [3:0] keys, input bit wr, input bit rd, input logic [15:0] d);
        int old;
        int k;
        logic [AW-1:0] nxt_addr;
        old      = m_state;
        nxt_addr = m_addr + 1'b1;
        if (m_pend) m_dac = m_pend_data;
        m_pend = rd;
        if (rd) m_pend_data = ref_mem[m_addr];
        if (wr) ref_mem[m_addr] = d;
        k = keys[3] ? 1 : keys[2] ? 2 : keys[1] ? 3 : keys[0] ? 4 : 0;
        case (old)
            ST_IDLE: begin
                if (k == 3) begin
                    m_state = ST_REC; m_addr = '0; m_end = '0;
                end else if (k == 4 && m_end != 0) begin
                    m_state = ST_PLAY; m_addr = '0;
                end
            end
            ST_REC: begin
                if (k == 1) m_state = ST_IDLE;
                else if (k == 2) begin m_state = ST_PAUSE; m_resume_rec = 1; end
                if (wr) begin
                    if (m_addr == AL) begin
                        m_end   = AW'(END_FULL);
                        m_state = ST_IDLE;
                    end else m_end = nxt_addr;
                    m_addr = nxt_addr;
                end
            end
            ST_PLAY: begin
                if (k == 1) m_state = ST_IDLE;
                else if (k == 2) begin m_state = ST_PAUSE; m_resume_rec = 0; end
                if (rd) begin
                    m_addr = nxt_addr;
                    if (nxt_addr == m_end) begin
`ifdef LOOP_PLAY_EN
                        m_addr = '0;
`else
                        m_state = ST_IDLE;
`endif
                    end
                end
            end
            default: begin
                if (k == 1) m_state = ST_IDLE;
                else if (k == 2 || k == 4) m_state = m_resume_rec ? ST_REC : ST_PLAY;
            end
        endcase
    endtask

    // One bclk cycle: drive at negedge, compare just before the rising edge, advance the model.
    task automatic cycle(input logic [3:0] keys, input bit ad, input logic [15:0] d, input bit dr);
        bit wr, rd;
        @(negedge bclk);
        {key_stop, key_pause, key_rec, key_play} = keys;
        adc_req = ad; adc_data = d; dac_req = dr;
        #2;
        wr = (m_state == ST_REC) && ad;
        rd = (m_state == ST_PLAY) && dr;
        obs_we_n = sif.sram_we_n; obs_oe_n = sif.sram_oe_n; obs_addr = sif.sram_addr;
        obs_valid = dac_valid; obs_data = dac_data; obs_end = end_addr; obs_state = state;
        check("state", state, m_state);
        check("end_addr", end_addr, m_end);
        check("dac_valid", dac_valid, m_pend);
        check("dac_data", dac_data, m_pend ? m_pend_data : m_dac);
        check("we_n", sif.sram_we_n, !wr);
        check("oe_n", sif.sram_oe_n, !rd);
        check("strobe_excl", sif.sram_we_n | sif.sram_oe_n, 1'b1);
        if (wr || rd) check("sram_addr", sif.sram_addr, m_addr);
        if (wr) check("sram_wdata", sif.sram_wdata, d);
        model_step(keys, wr, rd, d);
        @(posedge bclk);
        #1;
        {key_stop, key_pause, key_rec, key_play} = K_NO;
        adc_req = 0; dac_req = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_state"}, state, 0);
        check({tag, "_end"}, end_addr, 0);
        check({tag, "_valid"}, dac_valid, 0);
        check({tag, "_data"}, dac_data, 0);
        check({tag, "_we_n"}, sif.sram_we_n, 1);
        check({tag, "_oe_n"}, sif.sram_oe_n, 1);
        check({tag, "_addr"}, sif.sram_addr, 0);
        check({tag, "_wdata"}, sif.sram_wdata, 0);
    endtask

    // Reset raised mid-cycle while a request is active; outputs must clear before the next edge.
    task automatic async_reset(input bit ad, input bit dr);
        @(negedge bclk);
        adc_req = ad; adc_data = 16'hBEEF; dac_req = dr;
        #1 rst = 1'b1;
        #1 check_reset_values("async_rst");
        @(negedge bclk);
        adc_req = 0; dac_req = 0; rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rst = 1'b0;
        {key_stop, key_pause, key_rec, key_play} = K_NO;
        adc_req = 0; dac_req = 0; adc_data = '0;
        for (int i = 0; i < (1 << AW); i++) begin
            sram_mem[i] = '0;
            ref_mem[i]  = '0;
        end
        model_reset();
        #1 rst = 1'b1;
        #10 check_reset_values("por");
        @(negedge bclk);
        rst = 1'b0;

        // Record four samples then stop.
        cycle(K_REC, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle(K_NO, 1, 16'(16'h1111 * (i + 1)), 0);
            check("rec_addr", obs_addr, i);
            check("rec_we_n", obs_we_n, 0);
        end
        cycle(K_STOP, 0, 0, 0);
        cycle(K_NO, 0, 0, 0);
        check("rec_end_addr", obs_end, 4);
        check("rec_stopped", obs_state, ST_IDLE);

        // Play back; the fifth request falls after the end of the recording.
        cycle(K_PLAY, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(K_NO, 0, 0, 1);
`ifndef LOOP_PLAY_EN
            if (i == 4) check("play_extra_oe_n", obs_oe_n, 1);
`endif
            cycle(K_NO, 0, 0, 0);
            if (i < 4) begin
                check("play_valid", obs_valid, 1);
                check("play_data", obs_data, 16'h1111 * (i + 1));
            end
`ifndef LOOP_PLAY_EN
            if (i == 3) check("play_end_idle", obs_state, ST_IDLE);
            if (i == 4) check("play_extra_valid", obs_valid, 0);
`endif
        end

        // Pause at address 2; requests while paused are ignored.
        cycle(K_PLAY, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(K_NO, 0, 0, 1);
            cycle(K_NO, 0, 0, 0);
        end
        cycle(K_PAUSE, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            cycle(K_NO, 0, 0, 1);
            check("paused_oe_n", obs_oe_n, 1);
            check("paused_state", obs_state, ST_PAUSE);
        end
        cycle(K_PLAY, 0, 0, 0);
        cycle(K_NO, 0, 0, 1);
        check("resume_addr", obs_addr, 2);
        check("resume_oe_n", obs_oe_n, 0);
        cycle(K_NO, 0, 0, 0);
        check("resume_data", obs_data, 16'h3333);

        // Stop beats play when both pulse together.
        cycle(K_STOP | K_PLAY, 0, 0, 0);
        cycle(K_NO, 0, 0, 0);
        check("stop_prio", obs_state, ST_IDLE);

        // Reset during a read: no dac_valid afterwards; play refused with empty recording.
        cycle(K_PLAY, 0, 0, 0);
        async_reset(0, 1);
        cycle(K_NO, 0, 0, 0);
        check("rd_abort_valid", obs_valid, 0);
        cycle(K_PLAY, 0, 0, 0);
        cycle(K_NO, 0, 0, 0);
        check("play_empty", obs_state, ST_IDLE);

        // Reset during a write.
        cycle(K_REC, 0, 0, 0);
        cycle(K_NO, 1, 16'h5A5A, 0);
        async_reset(1, 0);
        cycle(K_NO, 0, 0, 0);
        check("wr_abort_end", obs_end, 0);

        // Pause during recording; key_rec is ignored while paused.
        cycle(K_REC, 0, 0, 0);
        cycle(K_NO, 1, 16'hAAAA, 0);
        cycle(K_PAUSE, 0, 0, 0);
        cycle(K_REC, 1, 16'hBBBB, 0);
        check("pause_rec_we_n", obs_we_n, 1);
        cycle(K_NO, 0, 0, 0);
        check("pause_rec_state", obs_state, ST_PAUSE);
        cycle(K_PAUSE, 0, 0, 0);
        cycle(K_NO, 1, 16'hCCCC, 0);
        check("resume_rec_addr", obs_addr, 1);
        check("resume_rec_we_n", obs_we_n, 0);
        cycle(K_STOP, 0, 0, 0);

        // Fill the whole memory; the last write ends recording with a saturated end_addr.
        cycle(K_REC, 0, 0, 0);
        for (int i = 0; i <= AL; i++) cycle(K_NO, 1, 16'(16'h0100 + i), 0);
        cycle(K_NO, 1, 16'hDEAD, 0);
        check("full_end", obs_end, END_FULL);
        check("full_state", obs_state, ST_IDLE);
        check("full_extra_we_n", obs_we_n, 1);

`ifdef LOOP_PLAY_EN
        cycle(K_REC, 0, 0, 0);
        cycle(K_NO, 1, 16'h0A0A, 0);
        cycle(K_NO, 1, 16'h0B0B, 0);
        cycle(K_STOP, 0, 0, 0);
        cycle(K_PLAY, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(K_NO, 0, 0, 1);
            check("loop_addr", obs_addr, i % 2);
            cycle(K_NO, 0, 0, 0);
        end
        check("loop_state", obs_state, ST_PLAY);
        cycle(K_STOP, 0, 0, 0);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            logic [3:0] keys;
            for (int b = 0; b < 4; b++) keys[b] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 149) == 0)
                async_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                cycle(keys, 1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
